br_tag_alloc: RTL and testbench

//  Branch-tag (branch-stack slot) allocator and scheduler for the dispatch stage.

---
 rtl/br_tag_alloc.sv | 101 ++++++++++
 tb/tb_br_tag_alloc.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/br_tag_alloc.sv
// Branch-tag allocator for dispatch: grants the lowest free one-hot tag, tracks
// per-tag dependency masks, frees tags on resolve and builds the mispredict squash mask.
module br_tag_alloc #(
  parameter int BR_TAGS = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         alloc_req,
  output logic                         alloc_gnt,
  output logic [BR_TAGS-1:0]           alloc_tag,
  output logic [BR_TAGS-1:0]           alloc_dep_mask,
  output logic [BR_TAGS-1:0]           dispatch_mask,
  output logic                         bs_full,
  output logic [$clog2(BR_TAGS+1)-1:0] free_cnt,
  input  logic                         resolve_valid,
  input  logic [BR_TAGS-1:0]           resolve_tag,
  input  logic                         resolve_mispred,
  output logic                         squash_valid,
  output logic [BR_TAGS-1:0]           squash_mask
);

  localparam int CW = $clog2(BR_TAGS+1);

  logic [BR_TAGS-1:0] busy_q, busy_d;
  logic [BR_TAGS-1:0] dep_q [BR_TAGS];
  logic [BR_TAGS-1:0] dep_d [BR_TAGS];

  logic               res_onehot;
  logic               res_ok;
  logic [BR_TAGS-1:0] younger;
  logic [BR_TAGS-1:0] res_clr;
  logic [BR_TAGS-1:0] free_onehot;
  logic               free_found;
  logic [CW-1:0]      free_cnt_c;

  always_comb begin
    res_onehot = (resolve_tag != '0) &&
                 ((resolve_tag & (resolve_tag - BR_TAGS'(1))) == '0);
    // Resolves that are malformed or miss every busy tag are dropped entirely.
    res_ok     = ~reset & resolve_valid & res_onehot & (|(resolve_tag & busy_q));

    younger = '0;
    for (int unsigned u = 0; u < BR_TAGS; u++) begin
      younger[u] = |(dep_q[u] & resolve_tag);
    end

    squash_valid = res_ok & resolve_mispred;
    squash_mask  = squash_valid ? (resolve_tag | younger) : '0;
    res_clr      = (res_ok & ~resolve_mispred) ? resolve_tag : '0;

    bs_full   = &busy_q;
    alloc_gnt = ~reset & alloc_req & ~bs_full & ~squash_valid;

    free_onehot = '0;
    free_found  = 1'b0;
    free_cnt_c  = '0;
    for (int unsigned i = 0; i < BR_TAGS; i++) begin
      if (!busy_q[i]) begin
        free_cnt_c = free_cnt_c + CW'(1);
        if (!free_found) begin
          free_onehot[i] = 1'b1;
          free_found     = 1'b1;
        end
      end
    end

    alloc_tag      = alloc_gnt ? free_onehot : '0;
    alloc_dep_mask = busy_q;
    dispatch_mask  = busy_q;
    free_cnt       = free_cnt_c;
  end

  always_comb begin
    busy_d = (busy_q & ~res_clr & ~squash_mask) | alloc_tag;
    for (int unsigned u = 0; u < BR_TAGS; u++) begin
      dep_d[u] = dep_q[u] & ~res_clr;
      if (res_clr[u] || squash_mask[u]) begin
        dep_d[u] = '0;
      end
      // A new branch depends on everything still live after this cycle's correct resolve.
      if (alloc_tag[u]) begin
        dep_d[u] = busy_q & ~res_clr;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      for (int unsigned u = 0; u < BR_TAGS; u++) begin
        dep_q[u] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int unsigned u = 0; u < BR_TAGS; u++) begin
        dep_q[u] <= dep_d[u];
      end
    end
  end

endmodule

// File: tb/tb_br_tag_alloc.sv
// Bench for br_tag_alloc: age-ordered queue model compared every cycle, plus
// directed scenarios with literal expectations and a randomized phase.
module tb_br_tag_alloc;

  localparam int N = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       alloc_req = 1'b0;
  logic       resolve_valid = 1'b0;
  logic [3:0] resolve_tag = '0;
  logic       resolve_mispred = 1'b0;
  logic       alloc_gnt, bs_full, squash_valid;
  logic [3:0] alloc_tag, alloc_dep_mask, dispatch_mask, squash_mask;
  logic [2:0] free_cnt;

  int checks = 0;
  int errors = 0;

  // Live tags, oldest first: a tag depends on every tag ahead of it.
  int q[$];

  logic       e_ok, e_sv, e_gnt, e_full;
  logic [3:0] e_sm, e_tag, e_dep, e_disp;
  logic [2:0] e_free;
  int         e_pos, e_idx;

  br_tag_alloc #(.BR_TAGS(N)) dut (
    .clock(clock), .reset(reset), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .alloc_tag(alloc_tag), .alloc_dep_mask(alloc_dep_mask), .dispatch_mask(dispatch_mask),
    .bs_full(bs_full), .free_cnt(free_cnt), .resolve_valid(resolve_valid),
    .resolve_tag(resolve_tag), .resolve_mispred(resolve_mispred),
    .squash_valid(squash_valid), .squash_mask(squash_mask)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void compute();
    logic [3:0] bm;
    bm = '0;
    foreach (q[i]) bm[q[i]] = 1'b1;
    e_ok = 1'b0; e_sv = 1'b0; e_sm = '0; e_pos = -1; e_idx = -1;
    e_gnt = 1'b0; e_tag = '0;
    if (reset) begin
      e_dep = '0; e_disp = '0; e_full = 1'b0; e_free = 3'(N);
      return;
    end
    e_ok = resolve_valid && ($countones(resolve_tag) == 1) && ((resolve_tag & bm) != '0);
    if (e_ok) foreach (q[i]) if (resolve_tag[q[i]]) e_pos = i;
    if (e_ok && resolve_mispred) begin
      e_sv = 1'b1;
      for (int i = e_pos; i < q.size(); i++) e_sm[q[i]] = 1'b1;
    end
    e_full = (q.size() == N);
    e_free = 3'(N - q.size());
    e_gnt  = alloc_req && !e_full && !e_sv;
    if (e_gnt) begin
      for (int i = 0; i < N; i++) if (!bm[i] && e_idx < 0) e_idx = i;
      e_tag[e_idx] = 1'b1;
    end
    e_dep  = bm;
    e_disp = bm;
  endfunction

  function automatic void update();
    compute();
    if (reset) begin
      q.delete();
    end else begin
      if (e_ok) begin
        if (resolve_mispred) begin
          while (q.size() > e_pos) void'(q.pop_back());
        end else begin
          q.delete(e_pos);
        end
      end
      if (e_gnt) q.push_back(e_idx);
    end
  endfunction

  initial begin
    forever begin
      @(negedge clock);
      compute();
      chk("alloc_gnt",      alloc_gnt,      e_gnt);
      chk("alloc_tag",      alloc_tag,      e_tag);
      chk("alloc_dep_mask", alloc_dep_mask, e_dep);
      chk("dispatch_mask",  dispatch_mask,  e_disp);
      chk("bs_full",        bs_full,        e_full);
      chk("free_cnt",       free_cnt,       e_free);
      chk("squash_valid",   squash_valid,   e_sv);
      chk("squash_mask",    squash_mask,    e_sm);
      @(posedge clock);
      update();
    end
  end

  task automatic step(input logic r, input logic req, input logic rv,
                      input logic [3:0] rt, input logic mp);
    @(posedge clock);
    #1;
    reset = r; alloc_req = req; resolve_valid = rv; resolve_tag = rt; resolve_mispred = mp;
    @(negedge clock);
    #1;
  endtask

  initial begin
    step(1, 0, 0, 4'b0000, 0);
    chk("rst_free", free_cnt, 3'd4);
    chk("rst_full", bs_full, 1'b0);
    step(1, 1, 0, 4'b0000, 0);
    chk("rst_gnt", alloc_gnt, 1'b0);

    // fill from empty
    step(0, 1, 0, 4'b0000, 0); chk("t1_tag0", alloc_tag, 4'b0001); chk("t1_dep0", alloc_dep_mask, 4'b0000);
    step(0, 1, 0, 4'b0000, 0); chk("t1_tag1", alloc_tag, 4'b0010); chk("t1_dep1", alloc_dep_mask, 4'b0001);
    step(0, 1, 0, 4'b0000, 0); chk("t1_tag2", alloc_tag, 4'b0100); chk("t1_dep2", alloc_dep_mask, 4'b0011);
    step(0, 1, 0, 4'b0000, 0); chk("t1_tag3", alloc_tag, 4'b1000); chk("t1_dep3", alloc_dep_mask, 4'b0111);
    step(0, 0, 0, 4'b0000, 0); chk("t1_full", bs_full, 1'b1); chk("t1_free", free_cnt, 3'd0);

    // full, then correct resolve of tag 1 and refill
    step(0, 1, 0, 4'b0000, 0); chk("t2_nognt", alloc_gnt, 1'b0); chk("t2_notag", alloc_tag, 4'b0000);
    step(0, 0, 1, 4'b0010, 0); chk("t2_nosq", squash_valid, 1'b0);
    step(0, 0, 0, 4'b0000, 0); chk("t2_full", bs_full, 1'b0); chk("t2_free", free_cnt, 3'd1);
    step(0, 1, 0, 4'b0000, 0); chk("t2_tag", alloc_tag, 4'b0010); chk("t2_dep", alloc_dep_mask, 4'b1101);
    step(0, 0, 1, 4'b0100, 1); chk("t2_sqv", squash_valid, 1'b1); chk("t2_sqm", squash_mask, 4'b1110);
    step(0, 0, 0, 4'b0000, 0); chk("t2_disp", dispatch_mask, 4'b0001);

    // tags 0..3 in order, mispredict tag 1
    step(0, 0, 1, 4'b0001, 0);
    repeat (4) step(0, 1, 0, 4'b0000, 0);
    step(0, 0, 1, 4'b0010, 1); chk("t3_sqv", squash_valid, 1'b1); chk("t3_sqm", squash_mask, 4'b1110);
    step(0, 0, 0, 4'b0000, 0); chk("t3_disp", dispatch_mask, 4'b0001); chk("t3_free", free_cnt, 3'd3);

    // mispredict beats a same-cycle alloc request
    step(0, 1, 0, 4'b0000, 0); chk("t4_tag", alloc_tag, 4'b0010);
    step(0, 1, 1, 4'b0001, 1); chk("t4_nognt", alloc_gnt, 1'b0); chk("t4_sqm", squash_mask, 4'b0011);
    chk("t4_disp", dispatch_mask, 4'b0011);
    step(0, 1, 0, 4'b0000, 0); chk("t4_tag2", alloc_tag, 4'b0001); chk("t4_dep2", alloc_dep_mask, 4'b0000);

    // correct resolve and grant together
    step(0, 1, 0, 4'b0000, 0); chk("t5_tag1", alloc_tag, 4'b0010);
    step(0, 1, 1, 4'b0001, 0); chk("t5_tag", alloc_tag, 4'b0100); chk("t5_dep", alloc_dep_mask, 4'b0011);
    step(0, 0, 0, 4'b0000, 0); chk("t5_disp", dispatch_mask, 4'b0110);
    step(0, 0, 1, 4'b0010, 1); chk("t5_sqm", squash_mask, 4'b0110);

    // illegal resolves are ignored
    step(0, 1, 0, 4'b0000, 0); chk("t6_tag", alloc_tag, 4'b0001);
    step(0, 0, 1, 4'b1000, 1); chk("t6_nb_sqv", squash_valid, 1'b0); chk("t6_nb_sqm", squash_mask, 4'b0000);
    step(0, 1, 0, 4'b0000, 0);
    step(0, 1, 0, 4'b0000, 0);
    step(0, 0, 1, 4'b0110, 1); chk("t6_oh_sqv", squash_valid, 1'b0); chk("t6_oh_sqm", squash_mask, 4'b0000);
    step(0, 0, 0, 4'b0000, 0); chk("t6_disp", dispatch_mask, 4'b0111);

    for (int n = 0; n < 3000; n++) begin
      logic [3:0] rt;
      if ($urandom_range(3) == 0) rt = 4'($urandom_range(15));
      else rt = 4'(1 << $urandom_range(3));
      step(($urandom_range(199) == 0), ($urandom_range(9) < 6), ($urandom_range(9) < 4),
           rt, ($urandom_range(9) < 3));
    end

    // reset in the middle of traffic
    step(0, 1, 0, 4'b0000, 0);
    step(0, 1, 0, 4'b0000, 0);
    step(1, 1, 1, 4'b0001, 1);
    chk("t6_rst_gnt", alloc_gnt, 1'b0); chk("t6_rst_tag", alloc_tag, 4'b0000);
    chk("t6_rst_disp", dispatch_mask, 4'b0000); chk("t6_rst_free", free_cnt, 3'd4);
    chk("t6_rst_sqv", squash_valid, 1'b0);
    step(0, 1, 0, 4'b0000, 0); chk("t6_post_tag", alloc_tag, 4'b0001);
    step(0, 0, 0, 4'b0000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
